dense_argmax_classifier: RTL and testbench

- Sits directly downstream of the parallel dense layer.
- Captures the layer's OUTPUT_SIZE signed fixed-point logits in one cycle, then scans them serially, one compare per clock.
- Emits the winning class index and its score over a valid/ready handshake.
- Frees the dense stage to present the next frame as soon as capture completes.

---
 rtl/dense_argmax_classifier.sv | 193 +++++++++++++++++++
 tb/tb_dense_argmax_classifier.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dense_argmax_classifier.sv
// dense_argmax_classifier
// Captures a full frame of signed logits from the dense layer in one cycle,
// scans the captured copy one element per clock, and returns the index and
// score of the largest logit over a valid/ready handshake. Strict compare,
// so the lowest index wins on ties.
// Optional build macro ARGMAX_MARGIN_EN adds a "margin" output: the distance
// between the best and the second-best logit, saturated to WIDTH bits.
module dense_argmax_classifier #(
    parameter int WIDTH       = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [NUM_CLASSES-1:0][WIDTH-1:0]   logits,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [IDX_W-1:0]                    class_idx,
    output logic signed [WIDTH-1:0]             max_value
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic [WIDTH-1:0]                    margin
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_CLASSES - 1);
    // With a single class there is nothing to scan; keep cnt at 0.
    localparam logic [IDX_W-1:0]        FIRST_SCAN = (NUM_CLASSES > 1) ? IDX_W'(1) : '0;
    localparam logic signed [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t                   state_q, state_d;
    logic signed [WIDTH-1:0]  lbuf_q [NUM_CLASSES];
    logic signed [WIDTH-1:0]  lbuf_d [NUM_CLASSES];
    logic signed [WIDTH-1:0]  best_val_q, best_val_d;
    logic [IDX_W-1:0]         best_idx_q, best_idx_d;
    logic [IDX_W-1:0]         cnt_q, cnt_d;
`ifdef ARGMAX_MARGIN_EN
    logic signed [WIDTH-1:0]  second_q, second_d;
`endif

    logic                     accept;
    logic                     last_step;
    logic signed [WIDTH-1:0]  cand;

    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == LAST_IDX);
    assign cand      = lbuf_q[cnt_q];

`ifdef ARGMAX_MARGIN_EN
    // best - second at WIDTH+1 bits, clamped into the unsigned WIDTH-bit range.
    function automatic logic [WIDTH-1:0] sat_margin(input logic signed [WIDTH-1:0] hi,
                                                    input logic signed [WIDTH-1:0] lo);
        logic [WIDTH:0] diff;
        logic [WIDTH:0] cap;
        cap  = {1'b0, {WIDTH{1'b1}}};
        diff = {hi[WIDTH-1], hi} - {lo[WIDTH-1], lo};
        if (hi < lo) begin
            return '0;
        end
        if (diff > cap) begin
            return '1;
        end
        return diff[WIDTH-1:0];
    endfunction
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture, serial scan, hold result until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (NUM_CLASSES > 1) ? SCAN : DONE;
                end
            end
            SCAN: begin
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; results are only shown while DONE.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        class_idx = out_valid ? best_idx_q : '0;
        max_value = out_valid ? best_val_q : '0;
`ifdef ARGMAX_MARGIN_EN
        margin    = '0;
        if (out_valid && (NUM_CLASSES > 1)) begin
            margin = sat_margin(best_val_q, second_q);
        end
`endif
    end

    // Datapath next values: frame capture in IDLE, one signed compare per SCAN cycle.
    always_comb begin
        lbuf_d     = lbuf_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        cnt_d      = cnt_q;
`ifdef ARGMAX_MARGIN_EN
        second_d   = second_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int k = 0; k < NUM_CLASSES; k++) begin
                        lbuf_d[k] = $signed(logits[k]);
                    end
                    best_val_d = $signed(logits[0]);
                    best_idx_d = '0;
                    cnt_d      = FIRST_SCAN;
`ifdef ARGMAX_MARGIN_EN
                    second_d   = MOST_NEG;
`endif
                end
            end
            SCAN: begin
                if (cand > best_val_q) begin
                    best_val_d = cand;
                    best_idx_d = cnt_q;
`ifdef ARGMAX_MARGIN_EN
                    second_d   = best_val_q;
`endif
                end
`ifdef ARGMAX_MARGIN_EN
                else if (cand > second_q) begin
                    second_d = cand;
                end
`endif
                // Hold at the last index so cnt never runs past the frame.
                if (!last_step) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_CLASSES; k++) begin
                lbuf_q[k] <= '0;
            end
            best_val_q <= '0;
            best_idx_q <= '0;
            cnt_q      <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= '0;
`endif
        end else begin
            lbuf_q     <= lbuf_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            cnt_q      <= cnt_d;
`ifdef ARGMAX_MARGIN_EN
            second_q   <= second_d;
`endif
        end
    end

    // The most-negative constant is only consumed by the margin logic.
    logic unused_most_neg;
    assign unused_most_neg = ^MOST_NEG;

endmodule

// File: tb/tb_dense_argmax_classifier.sv
// Scoreboard bench for dense_argmax_classifier: the driver pushes the expected
// result of each frame, a negedge monitor pops and compares on every handoff.
module tb_dense_argmax_classifier;

    localparam int W  = 16;
    localparam int N  = 10;
    localparam int IW = 4;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                in_valid;
    logic                in_ready;
    logic [N-1:0][W-1:0] logits;
    logic                out_valid;
    logic                out_ready;
    logic [IW-1:0]       class_idx;
    logic [W-1:0]        max_value;
`ifdef ARGMAX_MARGIN_EN
    logic [W-1:0]        margin;
`endif

    typedef struct {
        logic [IW-1:0] idx;
        logic [W-1:0]  val;
        logic [W-1:0]  mar;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    bit   ov_prev = 1'b0;
    bit   ho_prev = 1'b0;

    always #5 clk = ~clk;

    dense_argmax_classifier #(
        .WIDTH(W), .NUM_CLASSES(N), .IDX_W(IW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .logits    (logits),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx),
        .max_value (max_value)
`ifdef ARGMAX_MARGIN_EN
        ,
        .margin    (margin)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: latency, handshake rules and scoreboard comparison.
    always @(negedge clk) begin
        if (!reset_n) begin
            ov_prev = 1'b0;
            ho_prev = 1'b0;
        end else begin
            if (ho_prev) check("in_ready_after_handoff", {31'd0, in_ready}, 32'd1);
            if (in_valid && in_ready) acc_cyc = cyc + 1;
            if (out_valid && !ov_prev) check("latency", cyc - acc_cyc, 32'd9);
            if (out_valid && out_ready) begin
                check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: got idx %0d val %0h, expected no result", class_idx, max_value);
                end else begin
                    e = sb.pop_front();
                    check("class_idx", {28'd0, class_idx}, {28'd0, e.idx});
                    check("max_value", {16'd0, max_value}, {16'd0, e.val});
`ifdef ARGMAX_MARGIN_EN
                    check("margin", {16'd0, margin}, {16'd0, e.mar});
`endif
                end
            end
            ho_prev = out_valid && out_ready;
            ov_prev = out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [N-1:0][W-1:0] f, input bit exp_it,
                        input logic [IW-1:0] ei, input logic [W-1:0] ev, input logic [W-1:0] em);
        int t;
        t = 0;
        while (!in_ready && t < 300) begin
            tick();
            t++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL in_ready_timeout: got in_ready 0, expected 1 within 300 cycles");
        end
        logits   = f;
        in_valid = 1'b1;
        if (exp_it) sb.push_back('{ei, ev, em});
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 300) begin
            tick();
            t++;
        end
        if (sb.size() != 0 || !in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_class_idx", {28'd0, class_idx}, 32'd0);
        check("rst_max_value", {16'd0, max_value}, 32'd0);
`ifdef ARGMAX_MARGIN_EN
        check("rst_margin", {16'd0, margin}, 32'd0);
`endif
    endtask

    initial begin
        logic [N-1:0][W-1:0] f;
        logic [N-1:0][W-1:0] pulse;
        int t;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        logits    = '0;
        #2;
        check_reset_outputs();
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Ascending ramp: last class wins.
        for (int k = 0; k < N; k++) f[k] = 16'(k * 256);
        send(f, 1'b1, 4'd9, 16'h0900, 16'h0100);

        // All negative: signed compare picks -0x0010.
        f    = '0;
        f[0] = 16'hFC00;
        f[1] = 16'hFB00;
        f[2] = 16'hF800;
        f[3] = 16'hFFF0;
        for (int k = 4; k < N; k++) f[k] = 16'hF000;
        send(f, 1'b1, 4'd3, 16'hFFF0, 16'h03F0);

        // Tie between classes 2 and 7: lowest index wins.
        f    = '0;
        f[2] = 16'h0500;
        f[7] = 16'h0500;
        send(f, 1'b1, 4'd2, 16'h0500, 16'h0000);

        // Backpressure: result must hold while in_valid pulses are ignored.
        wait_idle();
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) f[k] = 16'h0100;
        f[4] = 16'h1234;
        send(f, 1'b1, 4'd4, 16'h1234, 16'h1134);
        t = 0;
        while (!out_valid && t < 50) begin
            tick();
            t++;
        end
        for (int k = 0; k < N; k++) pulse[k] = 16'h7FFF;
        for (int i = 0; i < 20; i++) begin
            logits   = pulse;
            in_valid = (i % 2 == 0);
            tick();
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_class_idx", {28'd0, class_idx}, 32'd4);
            check("bp_max_value", {16'd0, max_value}, 32'h1234);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // All equal at the most-negative value: class 0.
        for (int k = 0; k < N; k++) f[k] = 16'h8000;
        send(f, 1'b1, 4'd0, 16'h8000, 16'h0000);
        wait_idle();

        // Abort a frame mid-scan with reset.
        for (int k = 0; k < N; k++) f[k] = 16'h7000;
        f[0] = 16'h7FFF;
        send(f, 1'b0, 4'd0, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_hold_out_valid", {31'd0, out_valid}, 32'd0);
        end
        reset_n = 1'b1;
        tick();

        // Fresh frame after the abort.
        f    = '0;
        f[1] = 16'h7FFF;
        send(f, 1'b1, 4'd1, 16'h7FFF, 16'h7FFF);

        // Extreme spread: margin saturates.
        for (int k = 0; k < N; k++) f[k] = 16'h8000;
        f[0] = 16'h7FFF;
        send(f, 1'b1, 4'd0, 16'h7FFF, 16'hFFFF);

        wait_idle();
        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
